// File: rtl/mul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mul_arbiter                                                     |
// | Brief    : Round-robin arbiter sharing one sequential multiplier between   |
// |            two requesters, with ready/done/ack handshakes on both sides.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mul_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               req0_ready,
    output logic               req0_done,
    output logic               req0_err,
    output logic [2*WIDTH-1:0] req0_prod,
    input  logic               req0_ack,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req1_ready,
    output logic               req1_done,
    output logic               req1_err,
    output logic [2*WIDTH-1:0] req1_prod,
    input  logic               req1_ack,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic               mul_valid_data,
    output logic               mul_ack,
    input  logic               mul_done_flag,
    input  logic [2*WIDTH-1:0] mul_producto
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(TIMEOUT);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BUSY  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]         r_state;
    logic               r_rr_ptr;
    logic               r_owner;
    logic               r_first;
    logic               r_err;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [2*WIDTH-1:0] r_res;

    logic [1:0]         w_state_nxt;
    logic               w_grant;
    logic               w_gsel;
    logic               w_owner_ack;
    logic               w_timeout;

    always_comb begin
        w_grant     = 1'b0;
        w_gsel      = r_rr_ptr;
        w_owner_ack = r_owner ? req1_ack : req0_ack;
        w_timeout   = (r_cnt == c_CNT_LAST);
        w_state_nxt = r_state;

        // Holding off while Done_Flag is still up keeps valid_data from rising over it.
        if (r_state == c_IDLE && !mul_done_flag) begin
            case ({req1_valid, req0_valid})
                2'b01:   begin w_grant = 1'b1; w_gsel = 1'b0; end
                2'b10:   begin w_grant = 1'b1; w_gsel = 1'b1; end
                2'b11:   begin w_grant = 1'b1; w_gsel = r_rr_ptr; end
                default: ;
            endcase
        end

        case (r_state)
            c_IDLE:  if (w_grant) w_state_nxt = c_BUSY;
            c_BUSY:  if (mul_done_flag || w_timeout) w_state_nxt = c_DRAIN;
            c_DRAIN: if (r_err || !mul_done_flag) w_state_nxt = c_RESP;
            c_RESP:  if (w_owner_ack) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_rr_ptr <= 1'b0;
            r_owner  <= 1'b0;
            r_first  <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_res    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_gsel;
                        r_op_a  <= w_gsel ? req1_a : req0_a;
                        r_op_b  <= w_gsel ? req1_b : req0_b;
                        r_cnt   <= '0;
                        r_first <= 1'b1;
                    end
                end
                c_BUSY: begin
                    r_first <= 1'b0;
                    if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + c_CNT_W'(1);
                    if (mul_done_flag) begin
                        r_res <= mul_producto;
                    end else if (w_timeout) begin
                        r_res <= '0;
                        r_err <= 1'b1;
                    end
                end
                c_RESP: begin
                    if (w_owner_ack) begin
                        r_rr_ptr <= ~r_owner;
                        r_err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_valid_data = (r_state == c_BUSY);
    assign mul_ack        = (r_state == c_DRAIN);
    assign mul_a          = r_op_a;
    assign mul_b          = r_op_b;

    assign req0_ready = mul_valid_data & r_first & ~r_owner;
    assign req1_ready = mul_valid_data & r_first &  r_owner;
    assign req0_done  = (r_state == c_RESP) & ~r_owner;
    assign req1_done  = (r_state == c_RESP) &  r_owner;
    assign req0_err   = req0_done & r_err;
    assign req1_err   = req1_done & r_err;
    assign req0_prod  = req0_done ? r_res : '0;
    assign req1_prod  = req1_done ? r_res : '0;

endmodule
`default_nettype wire
